// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: shares the 68000 bus between the CPU and one secondary master (BR/BG/BGACK, REQ/GRANT).
// Latency: BR on the first eligible DMA_REQ_IN edge; grant on the first AS_IN-low edge after BG_IN was seen.
// Backpressure: new BR held off CPU_SLOT edges after each release; forced release when BUS_MASTER_ARBITER_TIMEOUT_EN.
module bus_master_arbiter #(
    parameter int CPU_SLOT = 8,
    parameter int MAX_HOLD = 256,
    parameter int HOLD_W   = 9
) (
    input  logic CPUCLK_IN,
    input  logic RESET_IN,
    input  logic DMA_REQ_IN,
    input  logic BG_IN,
    input  logic AS_IN,
    output logic BR,
    output logic BGACK,
    output logic DMA_GRANT,
    output logic BUS_OWNER,
    output logic TIMEOUT_FLAG
);

`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] SLOT_LOAD = HOLD_W'(CPU_SLOT);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_WAIT_BUS,
        ST_GRANTED,
        ST_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] holdoff_q, holdoff_d;
    logic              rearm_q, rearm_d;
    logic              br_q, br_d;
    logic              gnt_q, gnt_d;
    logic              tf_q, tf_d;

    // Grant, owner select and BGACK are one register so they can never disagree.
    assign BR           = br_q;
    assign BGACK        = gnt_q;
    assign DMA_GRANT    = gnt_q;
    assign BUS_OWNER    = gnt_q;
    assign TIMEOUT_FLAG = tf_q;

    // State register; reset drops any tenure and returns the bus to the CPU at once.
    always_ff @(negedge CPUCLK_IN) begin
        if (RESET_IN) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            holdoff_q <= '0;
            rearm_q   <= 1'b1;
            br_q      <= 1'b0;
            gnt_q     <= 1'b0;
            tf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            holdoff_q <= holdoff_d;
            rearm_q   <= rearm_d;
            br_q      <= br_d;
            gnt_q     <= gnt_d;
            tf_q      <= tf_d;
        end
    end

    // Next-state and registered-output logic for the arbitration handshake.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        holdoff_d = holdoff_q;
        rearm_d   = rearm_q;
        br_d      = br_q;
        gnt_d     = gnt_q;
        tf_d      = tf_q;

        unique case (state_q)
            ST_IDLE: begin
                br_d  = 1'b0;
                gnt_d = 1'b0;
                if (holdoff_q != '0) begin
                    holdoff_d = holdoff_q - HOLD_ONE;
                end
                if (!DMA_REQ_IN) begin
                    rearm_d = 1'b1;
                end
                // The CPU slot is counted from the edge BGACK falls (RELEASE
                // counts too), so BR may return on the edge the count hits 0.
                if (DMA_REQ_IN && rearm_q && (holdoff_q <= HOLD_ONE)) begin
                    state_d = ST_REQUEST;
                    br_d    = 1'b1;
                end
            end

            ST_REQUEST: begin
                br_d = 1'b1;
                if (!DMA_REQ_IN) begin
                    state_d = ST_IDLE;
                    br_d    = 1'b0;
                end else if (BG_IN) begin
                    state_d = ST_WAIT_BUS;
                end
            end

            ST_WAIT_BUS: begin
                br_d = 1'b1;
                if (!DMA_REQ_IN) begin
                    state_d = ST_IDLE;
                    br_d    = 1'b0;
                end else if (!AS_IN) begin
                    // CPU cycle finished: BR drops on the same edge BGACK rises.
                    state_d = ST_GRANTED;
                    br_d    = 1'b0;
                    gnt_d   = 1'b1;
                    hold_d  = '0;
                    tf_d    = 1'b0;
                end
            end

            ST_GRANTED: begin
                gnt_d = 1'b1;
                if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_ONE;
                end
                if (!DMA_REQ_IN) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = 1'b0;
                    holdoff_d = SLOT_LOAD;
                end else if (TIMEOUT_EN && (hold_q == HOLD_LAST)) begin
                    // Forced end of tenure; the master must drop its request
                    // before it can be served again.
                    state_d   = ST_RELEASE;
                    gnt_d     = 1'b0;
                    holdoff_d = SLOT_LOAD;
                    tf_d      = 1'b1;
                    rearm_d   = 1'b0;
                end
            end

            ST_RELEASE: begin
                if (holdoff_q != '0) begin
                    holdoff_d = holdoff_q - HOLD_ONE;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                br_d    = 1'b0;
                gnt_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter: randomized tenures against an event-timeline model of the arbiter.
// Latency: expected output changes are predicted per edge number and matched by a monitor.
// Backpressure: CPU slot and timeout re-arm are modelled as earliest-BR edge arithmetic.
module tb_bus_master_arbiter;

    localparam int CPU_SLOT = 8;
    localparam int MAX_HOLD = 16;
    localparam int HOLD_W   = 9;
    // RELEASE always occupies one cycle, so BR cannot return sooner than two edges after BGACK falls.
    localparam int SLOT_GAP = (CPU_SLOT > 2) ? CPU_SLOT : 2;
    localparam int NEVER    = 1 << 30;

`ifdef BUS_MASTER_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic CPUCLK_IN = 1'b0;
    logic RESET_IN = 1'b1;
    logic DMA_REQ_IN = 1'b0;
    logic BG_IN = 1'b0;
    logic AS_IN = 1'b0;
    logic BR, BGACK, DMA_GRANT, BUS_OWNER, TIMEOUT_FLAG;

    bus_master_arbiter #(
        .CPU_SLOT(CPU_SLOT),
        .MAX_HOLD(MAX_HOLD),
        .HOLD_W  (HOLD_W)
    ) dut (
        .CPUCLK_IN   (CPUCLK_IN),
        .RESET_IN    (RESET_IN),
        .DMA_REQ_IN  (DMA_REQ_IN),
        .BG_IN       (BG_IN),
        .AS_IN       (AS_IN),
        .BR          (BR),
        .BGACK       (BGACK),
        .DMA_GRANT   (DMA_GRANT),
        .BUS_OWNER   (BUS_OWNER),
        .TIMEOUT_FLAG(TIMEOUT_FLAG)
    );

    always #5 CPUCLK_IN = ~CPUCLK_IN;

    typedef struct {
        logic [4:0] vec;
        int         edge_at;
    } ev_t;

    ev_t  exp_q[$];
    int   edge_no = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic [4:0] prev_vec = '0;

    // Model state: earliest edge a new BR may rise, the flag value, and whether a low request is owed.
    int   earliest = 0;
    logic exp_tf = 1'b0;
    bit   need_low = 1'b0;

    always @(negedge CPUCLK_IN) edge_no <= edge_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_no);
        end
    endtask

    function automatic logic [4:0] vec(input logic br, input logic gr, input logic tf);
        return {br, gr, gr, gr, tf};
    endfunction

    task automatic push(input logic [4:0] v, input int e);
        ev_t ev;
        ev.vec = v;
        ev.edge_at = e;
        exp_q.push_back(ev);
    endtask

    // Monitor: handshake invariants every cycle; every output change is matched against the next expected event.
    always @(posedge CPUCLK_IN) begin
        logic [4:0] cur;
        ev_t ev;
        if (mon_en) begin
            cur = {BR, BGACK, DMA_GRANT, BUS_OWNER, TIMEOUT_FLAG};
            check("br_bgack_overlap", 32'(BR & BGACK), 32'd0);
            check("grant_mirror", 32'({DMA_GRANT, BUS_OWNER}), 32'({BGACK, BGACK}));
            if (cur !== prev_vec) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got %b expected no change at edge %0d", cur, edge_no);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_outputs", 32'(cur), 32'(ev.vec));
                    check("event_edge", edge_no, ev.edge_at);
                end
                prev_vec = cur;
            end
        end
    end

    // One input vector for the next falling edge.
    task automatic apply(input logic rst, input logic req, input logic bg, input logic as_v);
        RESET_IN   = rst;
        DMA_REQ_IN = req;
        BG_IN      = bg;
        AS_IN      = as_v;
        @(posedge CPUCLK_IN);
    endtask

    // One secondary-master transaction: d idle edges, BG g edges after BR, AS busy a edges in WAIT_BUS,
    // tenure t edges. ab=1 aborts in REQUEST after k edges, ab=2 aborts in WAIT_BUS, rst_off>0 resets mid-tenure.
    task automatic txn(input int d, input int g, input int a, input int t, input int ab,
                       input int k, input int rst_off, input bit as_with_bg);
        int s, r, w, gnt, req_end, last, x;
        logic req, bg, as_v, rst;
        if (need_low && d < 1) d = 1;
        need_low = 1'b0;
        if (ab == 2 && a < 2) a = 2;
        s   = edge_no + 1 + d;
        r   = (s > earliest) ? s : earliest;
        w   = r + g;
        gnt = w + ((a > 1) ? a : 1);
        x   = 0;
        push(vec(1'b1, 1'b0, exp_tf), r);
        if (ab == 1) begin
            req_end = r + k;
            last    = req_end;
            w       = NEVER;
            gnt     = NEVER;
            push(vec(1'b0, 1'b0, exp_tf), req_end);
            earliest = req_end + 1;
        end else if (ab == 2) begin
            req_end = w + 1;
            last    = req_end;
            gnt     = NEVER;
            push(vec(1'b0, 1'b0, exp_tf), req_end);
            earliest = req_end + 1;
        end else begin
            exp_tf = 1'b0;
            push(vec(1'b0, 1'b1, 1'b0), gnt);
            if (rst_off > 0) begin
                x       = gnt + rst_off;
                req_end = x + 2;
                last    = x + 2;
                push(vec(1'b0, 1'b0, 1'b0), x);
                push(vec(1'b1, 1'b0, 1'b0), x + 1);
                push(vec(1'b0, 1'b0, 1'b0), x + 2);
                earliest = x + 3;
            end else if (TO_EN && t > MAX_HOLD) begin
                exp_tf = 1'b1;
                push(vec(1'b0, 1'b0, 1'b1), gnt + MAX_HOLD);
                req_end  = gnt + MAX_HOLD + 12;
                last     = req_end - 1;
                earliest = gnt + MAX_HOLD + SLOT_GAP;
                need_low = 1'b1;
            end else begin
                req_end = gnt + t;
                last    = req_end;
                push(vec(1'b0, 1'b0, 1'b0), req_end);
                earliest = req_end + SLOT_GAP;
            end
        end
        for (int e = edge_no + 1; e <= last; e++) begin
            rst = (x != 0) && (e == x);
            req = (e >= s) && (e < req_end);
            if (e < r)          bg = 1'($urandom_range(0, 1));
            else if (e < w)     bg = 1'b0;
            else if (e <= gnt)  bg = 1'b1;
            else                bg = 1'($urandom_range(0, 1));
            if (e < w)          as_v = as_with_bg ? 1'b0 : 1'($urandom_range(0, 1));
            else if (e < w + a) as_v = 1'b1;
            else if (e <= gnt)  as_v = 1'b0;
            else                as_v = 1'($urandom_range(0, 1));
            apply(rst, req, bg, as_v);
        end
    endtask

    initial begin
        @(posedge CPUCLK_IN);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        check("reset_outputs", 32'({BR, BGACK, DMA_GRANT, BUS_OWNER, TIMEOUT_FLAG}), 32'd0);
        prev_vec = '0;
        earliest = edge_no + 1;
        mon_en   = 1'b1;

        // Grant on cycle 4 after reset, 10-cycle tenure; next request re-asserted in the RELEASE cycle.
        txn(0, 2, 0, 10, 0, 1, 0, 1'b0);
        // AS busy for 5 cycles, rising together with BG.
        txn(0, 1, 5, 3, 0, 1, 0, 1'b1);
        // Request withdrawn in REQUEST before BG, then in WAIT_BUS while AS is busy.
        txn(2, 3, 0, 4, 1, 1, 0, 1'b0);
        txn(0, 2, 3, 4, 2, 1, 0, 1'b0);
        // Reset pulse in the middle of a tenure.
        txn(1, 1, 1, 6, 0, 1, 3, 1'b0);
        if (TO_EN) begin
            // Held past the limit, then a tenure of exactly MAX_HOLD cycles.
            txn(0, 1, 0, 30, 0, 1, 0, 1'b0);
            txn(0, 1, 0, MAX_HOLD, 0, 1, 0, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            txn(int'($urandom_range(0, 10)), int'($urandom_range(1, 4)), int'($urandom_range(0, 6)),
                int'($urandom_range(1, TO_EN ? 24 : 40)),
                (sel == 7) ? 1 : ((sel == 8) ? 2 : 0), int'($urandom_range(1, 3)),
                (sel == 9) ? int'($urandom_range(1, 5)) : 0, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 20; i++) apply(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("pending_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion expected finish within budget");
        $fatal(1, "watchdog expired");
    end

endmodule
